ntt_addr_gen: RTL and testbench
===============================

NTT_ADDR_GEN -- requirements
Module: ntt_addr_gen

Interface
REQ-001 SHALL have parameter LANES, default 4, butterflies issued per beat; matches the +4 step of the stage-config counter.
REQ-002 SHALL have parameter ADDR_W, default 10, coefficient address width (N up to 1024).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port i_reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_start  input  1  one-cycle transform start request.
REQ-006 SHALL have port i_point_configuration  input  3  selects N = 8 << cfg; sampled only on accepted i_start.
REQ-007 SHALL have port i_new_stage_trigger  input  1  stage-complete pulse from the stage-config block.
REQ-008 SHALL have port i_ready  input  1  downstream accepts the current beat.
REQ-009 SHALL have port o_valid  output  1  beat valid.
REQ-010 SHALL have port o_addr_a  output  LANES*ADDR_W  upper-leg addresses; lane l occupies bits [l*ADDR_W +: ADDR_W].
REQ-011 SHALL have port o_addr_b  output  LANES*ADDR_W  lower-leg addresses, same packing.
REQ-012 SHALL have port o_stage  output  4  current stage index, 0-based.
REQ-013 SHALL have port o_working  output  1  equals o_valid & i_ready; drives the stage-config counter enable.
REQ-014 SHALL have port o_busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port o_done  output  1  one-cycle pulse after the last stage completes.

Function
REQ-016 SHALL implement FSM IDLE -> ISSUE -> WAIT_TRIG -> (ISSUE | DONE) -> IDLE.
REQ-017 IDLE: i_start latches cfg, clears stage and beat counters, and enters ISSUE the next cycle; o_valid is asserted in the first ISSUE cycle.
REQ-018 ISSUE: o_valid=1; beat index j advances by 1 only when i_ready=1; the last beat (j = N/(2*LANES)-1) accepted -> WAIT_TRIG with o_valid=0 the next cycle.
REQ-019 Backpressure: while o_valid & !i_ready, o_addr_a, o_addr_b and o_stage SHALL hold stable.
REQ-020 Half-span h = (N/2) >> stage; butterfly k = j*LANES + l; a = ((k >> log2 h) << (log2 h + 1)) | (k & (h-1)); b = a + h; all unsigned ADDR_W bits with no overflow for N <= 1024.
REQ-021 WAIT_TRIG: i_new_stage_trigger=1 -> if stage = log2 N - 1 then DONE, else stage+1, j=0, ISSUE.
REQ-022 DONE: o_done=1 for exactly one cycle, then IDLE.
REQ-023 i_start is ignored outside IDLE; i_new_stage_trigger is ignored outside WAIT_TRIG.
REQ-024 Stages per transform = cfg+3; beats per stage = N/8 (cfg=0 -> 1 beat, cfg=7 -> 128 beats).
REQ-025 When o_valid=0, o_addr_a and o_addr_b SHALL hold their last values (no X).

Reset
REQ-026 Asserting i_reset SHALL immediately force IDLE with o_valid, o_working, o_busy and o_done = 0, o_addr_a, o_addr_b and o_stage = 0, and the latched cfg = 0.
REQ-027 Reset mid-transform SHALL abandon it; the first i_start after deassertion restarts from stage 0.

Structure
REQ-028 Package ntt_pkg SHALL hold the FSM state enum, LANES, ADDR_W, MAX_LOG_N=10 and the stage-count function.
REQ-029 A sub-module bfly_lane_addr (combinational k, log2 h -> a, b) SHALL be instantiated LANES times; sequencing stays in ntt_addr_gen.

Verification
REQ-030 cfg=0, i_ready=1, trigger 6 cycles after each final beat -> stage0 a={0,1,2,3} b={4,5,6,7}; stage1 a={0,1,4,5} b={2,3,6,7}; stage2 a={0,2,4,6} b={1,3,5,7}; o_done pulses once.
REQ-031 cfg=1 -> stage0 beats a={0..3},{4..7} with b=a+8; stage3 beat1 a={8,10,12,14} b={9,11,13,15}; 4 stages total.
REQ-032 Backpressure: cfg=2, i_ready low for 3 cycles mid-stage -> addresses are frozen, o_working=0, and no beat is skipped or duplicated.
REQ-033 i_start and i_new_stage_trigger pulsed during ISSUE -> both ignored; beat sequence unchanged.
REQ-034 i_reset asserted in WAIT_TRIG at stage 2 of cfg=7 -> all outputs 0 in the same cycle; next i_start with cfg=0 runs a clean 3-stage transform.
REQ-035 cfg=7 full run with random i_ready -> 10 stages x 128 beats; every address 0..1023 appears exactly once per stage (scoreboard).

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared constants, FSM state encoding and stage helper
// for the NTT butterfly address generator.
package ntt_pkg;

  localparam int LANES     = 4;
  localparam int ADDR_W    = 10;
  localparam int MAX_LOG_N = 10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // N = 8 << cfg, so a transform has log2(N) = cfg + 3 stages
  function automatic logic [3:0] stage_count(
    input logic [2:0] cfg
  );
    return 4'(cfg) + 4'd3;
  endfunction

endpackage

// File: rtl/bfly_lane_addr.sv
// One butterfly lane: maps butterfly index k and log2 of the
// half-span to the upper (a) and lower (b) leg addresses.
module bfly_lane_addr #(
  parameter int ADDR_W = ntt_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0] k,
  input  logic [3:0]        log_h,
  output logic [ADDR_W-1:0] a,
  output logic [ADDR_W-1:0] b
);

  logic [ADDR_W-1:0] h;
  logic [ADDR_W-1:0] hi;
  logic [ADDR_W-1:0] lo;

  assign h  = ADDR_W'(1) << log_h;
  // group index moves up one bit to leave room for the b leg
  assign hi = (k >> log_h) << (log_h + 4'd1);
  assign lo = k & (h - 1'b1);
  assign a  = hi | lo;
  assign b  = a + h;

endmodule

// File: rtl/ntt_addr_gen.sv
// Per-stage butterfly address sequencer for an in-place NTT,
// issuing LANES butterflies per beat with valid/ready flow.
module ntt_addr_gen #(
  parameter int LANES  = ntt_pkg::LANES,
  parameter int ADDR_W = ntt_pkg::ADDR_W
) (
  input  logic                    clk,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic [2:0]              i_point_configuration,
  input  logic                    i_new_stage_trigger,
  input  logic                    i_ready,
  output logic                    o_valid,
  output logic [LANES*ADDR_W-1:0] o_addr_a,
  output logic [LANES*ADDR_W-1:0] o_addr_b,
  output logic [3:0]              o_stage,
  output logic                    o_working,
  output logic                    o_busy,
  output logic                    o_done
);

  import ntt_pkg::*;

  state_e            state;
  logic [2:0]        cfg;
  logic [3:0]        stage;
  logic [ADDR_W-1:0] beat;
  logic              primed;

  logic [3:0]              log_h;
  logic [ADDR_W-1:0]       last_beat;
  logic                    last_stage;
  logic [LANES*ADDR_W-1:0] addr_a;
  logic [LANES*ADDR_W-1:0] addr_b;

  // h = (N/2) >> stage, with N/2 = 1 << (cfg + 2)
  assign log_h = 4'(cfg) + 4'd2 - stage;

  assign last_beat = ADDR_W'(
    ((32'd1 << (32'(cfg) + 32'd2)) / LANES) - 1
  );

  assign last_stage = stage == (stage_count(cfg) - 4'd1);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    bfly_lane_addr #(
      .ADDR_W(ADDR_W)
    ) u_lane (
      .k    (ADDR_W'(32'(beat) * LANES + l)),
      .log_h(log_h),
      .a    (addr_a[l*ADDR_W +: ADDR_W]),
      .b    (addr_b[l*ADDR_W +: ADDR_W])
    );
  end

  assign o_valid   = state == S_ISSUE;
  assign o_working = o_valid & i_ready;
  assign o_busy    = state != S_IDLE;
  assign o_done    = state == S_DONE;
  assign o_stage   = stage;

  // addresses read as zero until the first transform is issued
  assign o_addr_a = primed ? addr_a : '0;
  assign o_addr_b = primed ? addr_b : '0;

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state  <= S_IDLE;
      cfg    <= '0;
      stage  <= '0;
      beat   <= '0;
      primed <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (i_start) begin
            cfg    <= i_point_configuration;
            stage  <= '0;
            beat   <= '0;
            primed <= 1'b1;
            state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (i_ready) begin
            if (beat == last_beat) begin
              state <= S_WAIT;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (i_new_stage_trigger) begin
            if (last_stage) begin
              state <= S_DONE;
            end else begin
              stage <= stage + 4'd1;
              beat  <= '0;
              state <= S_ISSUE;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_addr_gen.sv
// Directed and table-driven bench for ntt_addr_gen,
// with a per-stage coverage scoreboard.
module tb_ntt_addr_gen;

  localparam int LANES = 4;
  localparam int AW    = 10;
  localparam int BW    = LANES * AW;

  logic          clk = 1'b0;
  logic          i_reset;
  logic          i_start;
  logic [2:0]    i_point_configuration;
  logic          i_new_stage_trigger;
  logic          i_ready;
  logic          o_valid;
  logic [BW-1:0] o_addr_a;
  logic [BW-1:0] o_addr_b;
  logic [3:0]    o_stage;
  logic          o_working;
  logic          o_busy;
  logic          o_done;

  ntt_addr_gen #(
    .LANES (LANES),
    .ADDR_W(AW)
  ) dut (
    .clk                  (clk),
    .i_reset              (i_reset),
    .i_start              (i_start),
    .i_point_configuration(i_point_configuration),
    .i_new_stage_trigger  (i_new_stage_trigger),
    .i_ready              (i_ready),
    .o_valid              (o_valid),
    .o_addr_a             (o_addr_a),
    .o_addr_b             (o_addr_b),
    .o_stage              (o_stage),
    .o_working            (o_working),
    .o_busy               (o_busy),
    .o_done               (o_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    cfg;
    int            idx;
    logic [3:0]    stage;
    logic [BW-1:0] a;
    logic [BW-1:0] b;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs[NV];

  int errors = 0;
  int checks = 0;

  logic [BW-1:0] cap_a[$];
  logic [BW-1:0] cap_b[$];
  logic [3:0]    cap_s[$];
  int            done_cnt;

  function automatic logic [BW-1:0] pk(
    int x0, int x1, int x2, int x3
  );
    return {AW'(x3), AW'(x2), AW'(x1), AW'(x0)};
  endfunction

  task automatic chk(
    input string       name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // mode 0: ready=1, 1: random ready,
  // 2: 3-cycle stall after 2 beats,
  // 3: start+trigger pulsed during ISSUE
  task automatic run_tx(
    input logic [2:0] cfg,
    input int         mode,
    input int         trig_dly
  );
    int            wait_cnt;
    int            stall_left;
    bit            finished;
    bit            once;
    bit            prev_stall;
    logic [BW-1:0] pa;
    logic [BW-1:0] pb;
    logic [3:0]    ps;
    cap_a.delete();
    cap_b.delete();
    cap_s.delete();
    done_cnt   = 0;
    wait_cnt   = 0;
    stall_left = 0;
    finished   = 0;
    once       = 0;
    prev_stall = 0;
    pa = '0;
    pb = '0;
    ps = '0;
    @(posedge clk); #1;
    i_start = 1'b1;
    i_point_configuration = cfg;
    i_ready = 1'b1;
    i_new_stage_trigger = 1'b0;
    @(posedge clk); #1;
    i_start = 1'b0;
    i_point_configuration = ~cfg;
    for (int c = 0; c < 20000 && !finished; c++) begin
      @(negedge clk);
      if (prev_stall) begin
        chk("stall_addr_a", 64'(o_addr_a), 64'(pa));
        chk("stall_addr_b", 64'(o_addr_b), 64'(pb));
        chk("stall_stage", 64'(o_stage), 64'(ps));
      end
      if (o_valid && !i_ready)
        chk("stall_working", 64'(o_working), 64'd0);
      prev_stall = o_valid && !i_ready;
      pa = o_addr_a;
      pb = o_addr_b;
      ps = o_stage;
      if (o_working) begin
        cap_a.push_back(o_addr_a);
        cap_b.push_back(o_addr_b);
        cap_s.push_back(o_stage);
      end
      if (o_done) begin
        done_cnt++;
        finished = 1;
      end
      @(posedge clk); #1;
      i_start = 1'b0;
      i_new_stage_trigger = 1'b0;
      if (o_busy && !o_valid && !o_done) begin
        wait_cnt++;
        if (wait_cnt == trig_dly)
          i_new_stage_trigger = 1'b1;
      end else begin
        wait_cnt = 0;
      end
      case (mode)
        1: i_ready = 1'($urandom_range(1));
        2: begin
          if (!once && cap_a.size() == 2) begin
            stall_left = 3;
            once = 1;
          end
          if (stall_left > 0) begin
            i_ready = 1'b0;
            stall_left--;
          end else begin
            i_ready = 1'b1;
          end
        end
        3: begin
          if (!once && o_valid && cap_a.size() == 1) begin
            i_start = 1'b1;
            i_new_stage_trigger = 1'b1;
            once = 1;
          end
        end
        default: i_ready = 1'b1;
      endcase
    end
    if (!finished)
      chk("timeout_done", 64'd0, 64'd1);
    i_start = 1'b0;
    i_new_stage_trigger = 1'b0;
    i_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (o_done) done_cnt++;
    end
    chk("done_pulses", 64'(done_cnt), 64'd1);
  endtask

  task automatic check_table(input logic [2:0] cfg);
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].cfg == cfg) begin
        if (vecs[i].idx >= cap_a.size()) begin
          chk("tbl_missing", 64'(cap_a.size()),
              64'(vecs[i].idx + 1));
        end else begin
          chk($sformatf("tbl%0d_stage", i),
              64'(cap_s[vecs[i].idx]),
              64'(vecs[i].stage));
          chk($sformatf("tbl%0d_a", i),
              64'(cap_a[vecs[i].idx]), 64'(vecs[i].a));
          chk($sformatf("tbl%0d_b", i),
              64'(cap_b[vecs[i].idx]), 64'(vecs[i].b));
        end
      end
    end
  endtask

  // every address of 0..N-1 once per stage, b-a = half-span
  task automatic check_cover(input logic [2:0] cfg);
    int n;
    int nst;
    int bps;
    int seen[1024];
    int cnt;
    int bad;
    int av;
    int bv;
    n   = 8 << cfg;
    nst = int'(cfg) + 3;
    bps = 1 << cfg;
    chk("num_beats", 64'(cap_a.size()), 64'(nst * bps));
    for (int s = 0; s < nst; s++) begin
      cnt = 0;
      bad = 0;
      for (int x = 0; x < 1024; x++) seen[x] = 0;
      for (int i = 0; i < cap_a.size(); i++) begin
        if (int'(cap_s[i]) == s) begin
          cnt++;
          for (int l = 0; l < LANES; l++) begin
            av = int'(cap_a[i][l*AW +: AW]);
            bv = int'(cap_b[i][l*AW +: AW]);
            if (bv - av != ((n / 2) >> s)) bad++;
            seen[av]++;
            seen[bv]++;
          end
        end
      end
      for (int x = 0; x < n; x++)
        if (seen[x] != 1) bad++;
      chk($sformatf("cover_cnt_s%0d", s),
          64'(cnt), 64'(bps));
      chk($sformatf("cover_bad_s%0d", s),
          64'(bad), 64'd0);
    end
  endtask

  initial begin
    bit hit;
    vecs[0] = '{3'd0, 0, 4'd0, pk(0, 1, 2, 3), pk(4, 5, 6, 7)};
    vecs[1] = '{3'd0, 1, 4'd1, pk(0, 1, 4, 5), pk(2, 3, 6, 7)};
    vecs[2] = '{3'd0, 2, 4'd2, pk(0, 2, 4, 6), pk(1, 3, 5, 7)};
    vecs[3] = '{3'd1, 0, 4'd0, pk(0, 1, 2, 3),
                pk(8, 9, 10, 11)};
    vecs[4] = '{3'd1, 1, 4'd0, pk(4, 5, 6, 7),
                pk(12, 13, 14, 15)};
    vecs[5] = '{3'd1, 3, 4'd1, pk(8, 9, 10, 11),
                pk(12, 13, 14, 15)};
    vecs[6] = '{3'd1, 7, 4'd3, pk(8, 10, 12, 14),
                pk(9, 11, 13, 15)};
    vecs[7] = '{3'd2, 2, 4'd0, pk(8, 9, 10, 11),
                pk(24, 25, 26, 27)};

    i_reset = 1'b1;
    i_start = 1'b0;
    i_point_configuration = 3'd0;
    i_new_stage_trigger = 1'b0;
    i_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_working", 64'(o_working), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_stage", 64'(o_stage), 64'd0);
    chk("rst_addr_a", 64'(o_addr_a), 64'd0);
    chk("rst_addr_b", 64'(o_addr_b), 64'd0);
    @(posedge clk); #1;
    i_reset = 1'b0;

    run_tx(3'd0, 0, 6);
    check_table(3'd0);
    check_cover(3'd0);

    run_tx(3'd1, 0, 6);
    check_table(3'd1);
    check_cover(3'd1);

    run_tx(3'd1, 3, 2);
    check_table(3'd1);
    check_cover(3'd1);

    run_tx(3'd2, 2, 3);
    check_table(3'd2);
    check_cover(3'd2);

    // abort a cfg=7 transform while waiting at stage 2
    hit = 0;
    @(posedge clk); #1;
    i_start = 1'b1;
    i_point_configuration = 3'd7;
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(posedge clk); #1;
      i_new_stage_trigger = 1'b0;
      if (o_busy && !o_valid && !o_done) begin
        if (o_stage == 4'd2) begin
          hit = 1;
          break;
        end
        i_new_stage_trigger = 1'b1;
      end
    end
    chk("abort_reached_stage2", 64'(hit), 64'd1);
    #2;
    i_reset = 1'b1;
    #1;
    chk("abort_valid", 64'(o_valid), 64'd0);
    chk("abort_working", 64'(o_working), 64'd0);
    chk("abort_busy", 64'(o_busy), 64'd0);
    chk("abort_done", 64'(o_done), 64'd0);
    chk("abort_stage", 64'(o_stage), 64'd0);
    chk("abort_addr_a", 64'(o_addr_a), 64'd0);
    chk("abort_addr_b", 64'(o_addr_b), 64'd0);
    @(posedge clk); #1;
    i_reset = 1'b0;

    run_tx(3'd0, 0, 6);
    check_table(3'd0);
    check_cover(3'd0);

    run_tx(3'd7, 1, 4);
    check_cover(3'd7);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
